// File: rtl/ray_pkg.sv
// Shared types for the pixel ray sequencer: frame size, float32 words,
// ray and tag bundles, and the sequencer state encoding.
package ray_pkg;

   localparam int FRAME_W = 512;
   localparam int FRAME_H = 384;

   typedef logic [31:0] float32_t;

   typedef struct packed {
      float32_t    dx;
      float32_t    dy;
      float32_t    dz;
      logic [10:0] px;
      logic [9:0]  py;
      logic        last;
   } ray_t;

   typedef struct packed {
      logic        valid;
      logic [10:0] px;
      logic [9:0]  py;
      logic        last;
   } pix_tag_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2
   } seq_state_e;

endpackage

// File: rtl/pixel_ray_sequencer_if.sv
// Ray handoff bus from the sequencer FIFO head to the intersection stage.
// Sequencer drives the master side; downstream owns ready.
interface pixel_ray_sequencer_if;
   import ray_pkg::*;

   logic        ray_valid_out;
   logic        ray_ready_in;
   float32_t    ray_dx_out;
   float32_t    ray_dy_out;
   float32_t    ray_dz_out;
   logic [10:0] ray_px_out;
   logic [9:0]  ray_py_out;
   logic        ray_last_out;

   modport master (
      output ray_valid_out, ray_dx_out, ray_dy_out, ray_dz_out,
      output ray_px_out, ray_py_out, ray_last_out,
      input  ray_ready_in
   );

   modport slave (
      input  ray_valid_out, ray_dx_out, ray_dy_out, ray_dz_out,
      input  ray_px_out, ray_py_out, ray_last_out,
      output ray_ready_in
   );

endinterface

// File: rtl/ray_fifo.sv
// Synchronous first-word-fall-through FIFO of ray_t; head is always on dout.
// Push and pop may coincide at any fill level.
module ray_fifo
   import ray_pkg::*;
#(
   parameter int DEPTH = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  ray_t                     din,
   output ray_t                     dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   ray_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/pixel_ray_sequencer.sv
// Raster scan feeding a fixed-latency direction pipeline with credit-based FIFO realignment.
// Optional PIXEL_SEQ_FRAME_CNT_EN adds frame_cnt_out and stall_cnt_out.
module pixel_ray_sequencer
   import ray_pkg::*;
#(
   parameter int PIPE_LATENCY = 64,
   parameter int FIFO_DEPTH   = 128,
   parameter int FRAME_W      = ray_pkg::FRAME_W,
   parameter int FRAME_H      = ray_pkg::FRAME_H
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_in,
   output logic        busy_out,
   output logic        frame_done_out,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   input  float32_t    dir_x_in,
   input  float32_t    dir_y_in,
   input  float32_t    dir_z_in,
`ifdef PIXEL_SEQ_FRAME_CNT_EN
   output logic [15:0] frame_cnt_out,
   output logic [31:0] stall_cnt_out,
   pixel_ray_sequencer_if.master ray
`else
   pixel_ray_sequencer_if.master ray
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(PIPE_LATENCY + 1);
   localparam int CW = $clog2(PIPE_LATENCY + FIFO_DEPTH + 1);
   localparam logic [10:0] X_MAX = 11'(FRAME_W - 1);
   localparam logic [9:0]  Y_MAX = 10'(FRAME_H - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]    state;
   logic [10:0]   x_cnt;
   logic [9:0]    y_cnt;
   logic [IW-1:0] inflight;
   pix_tag_t      tag_line [PIPE_LATENCY];
   pix_tag_t      exit_tag;
   logic [AW:0]   fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   ray_t          push_ray;
   ray_t          head;
   logic          credit;
   logic          issue;
   logic          last_pix;
   logic          pop;
   logic          done;

   // Every issue reserves a FIFO slot, so returning directions always fit.
   assign credit   = (CW'(inflight) + CW'(fifo_count)) < CW'(FIFO_DEPTH);
   assign issue    = (state == SCAN) && credit;
   assign last_pix = (x_cnt == X_MAX) && (y_cnt == Y_MAX);
   assign exit_tag = tag_line[PIPE_LATENCY-1];
   assign pop      = !fifo_empty && ray.ray_ready_in;
   assign done     = pop && head.last && (state == DRAIN);

   assign x_out          = x_cnt;
   assign y_out          = y_cnt;
   assign busy_out       = (state != IDLE);
   assign frame_done_out = done;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_in) begin
                  state <= SCAN;
                  x_cnt <= '0;
                  y_cnt <= '0;
               end
            end
            SCAN: begin
               if (issue) begin
                  if (x_cnt == X_MAX) begin
                     x_cnt <= '0;
                     if (y_cnt == Y_MAX) begin
                        y_cnt <= '0;
                        state <= DRAIN;
                     end else begin
                        y_cnt <= y_cnt + 1'b1;
                     end
                  end else begin
                     x_cnt <= x_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         inflight <= '0;
         for (int i = 0; i < PIPE_LATENCY; i++) tag_line[i] <= '0;
      end else begin
         tag_line[0] <= '{valid: issue, px: x_cnt, py: y_cnt, last: last_pix};
         for (int i = 1; i < PIPE_LATENCY; i++) tag_line[i] <= tag_line[i-1];
         if (issue && !exit_tag.valid)
            inflight <= inflight + 1'b1;
         else if (!issue && exit_tag.valid)
            inflight <= inflight - 1'b1;
      end
   end

   assign push_ray = '{dx: dir_x_in, dy: dir_y_in, dz: dir_z_in,
                       px: exit_tag.px, py: exit_tag.py, last: exit_tag.last};

   ray_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_in),
      .rst   (rst_in),
      .push  (exit_tag.valid),
      .pop   (pop),
      .din   (push_ray),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign ray.ray_valid_out = !fifo_empty;
   assign ray.ray_dx_out    = head.dx;
   assign ray.ray_dy_out    = head.dy;
   assign ray.ray_dz_out    = head.dz;
   assign ray.ray_px_out    = head.px;
   assign ray.ray_py_out    = head.py;
   assign ray.ray_last_out  = head.last;

   a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
      !(exit_tag.valid && fifo_full && !pop));

`ifdef PIXEL_SEQ_FRAME_CNT_EN
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         frame_cnt_out <= '0;
         stall_cnt_out <= '0;
      end else begin
         if (done) frame_cnt_out <= frame_cnt_out + 1'b1;
         if (state == IDLE && start_in)
            stall_cnt_out <= '0;
         else if (state == SCAN && !credit)
            stall_cnt_out <= stall_cnt_out + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_ray_sequencer.sv
// Scoreboard bench for pixel_ray_sequencer on a 4x3 frame, latency 8, FIFO depth 4.
module tb_pixel_ray_sequencer;
   import ray_pkg::*;

   localparam int L = 8;
   localparam int W = 4;
   localparam int H = 3;
   localparam int D = 4;

   typedef struct {
      logic [10:0] px;
      logic [9:0]  py;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        frame_done;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   float32_t    dir_x;
   float32_t    dir_y;
   float32_t    dir_z;
`ifdef PIXEL_SEQ_FRAME_CNT_EN
   logic [15:0] frame_cnt;
   logic [31:0] stall_cnt;
`endif

   pixel_ray_sequencer_if rif ();

   pixel_ray_sequencer #(
      .PIPE_LATENCY (L),
      .FIFO_DEPTH   (D),
      .FRAME_W      (W),
      .FRAME_H      (H)
   ) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .start_in       (start),
      .busy_out       (busy),
      .frame_done_out (frame_done),
      .x_out          (x_out),
      .y_out          (y_out),
      .dir_x_in       (dir_x),
      .dir_y_in       (dir_y),
      .dir_z_in       (dir_z),
`ifdef PIXEL_SEQ_FRAME_CNT_EN
      .frame_cnt_out  (frame_cnt),
      .stall_cnt_out  (stall_cnt),
`endif
      .ray            (rif.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_x(logic [10:0] x, logic [9:0] y);
      return {11'h2AB, x, y};
   endfunction
   function automatic logic [31:0] enc_y(logic [10:0] x, logic [9:0] y);
      return {y, x, 11'h155};
   endfunction

   // Direction pipeline model: pure L-cycle delay of x/y, encoded into dir_*
   logic [10:0] px_d [L];
   logic [9:0]  py_d [L];
   always @(posedge clk) begin
      px_d[0] <= x_out;
      py_d[0] <= y_out;
      for (int i = 1; i < L; i++) begin
         px_d[i] <= px_d[i-1];
         py_d[i] <= py_d[i-1];
      end
   end
   assign dir_x = enc_x(px_d[L-1], py_d[L-1]);
   assign dir_y = enc_y(px_d[L-1], py_d[L-1]);
   assign dir_z = ~enc_x(px_d[L-1], py_d[L-1]);

   int   checks = 0;
   int   errors = 0;
   exp_t q [$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            q.push_back('{px: 11'(x), py: 10'(y),
                          last: (x == W-1) && (y == H-1)});
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_frame(int max_cyc);
      int i;
      for (i = 0; i < max_cyc; i++) begin
         @(posedge clk); #1;
         if (q.size() == 0 && !busy) break;
      end
      checks++;
      if (i >= max_cyc) begin
         errors++;
         $display("FAIL frame_timeout: got %0d rays pending, busy %0b expected 0",
                  q.size(), busy);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted ray
   logic [117:0] cur, prev_data;
   logic         prev_stall = 1'b0;
   logic         busy_chk = 1'b0;
   exp_t         e;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         busy_chk   = 1'b0;
      end else begin
         if (busy_chk) begin
            chk("busy_after_done", 32'(busy), 32'd0);
            busy_chk = 1'b0;
         end
         cur = {rif.ray_dx_out, rif.ray_dy_out, rif.ray_dz_out,
                rif.ray_px_out, rif.ray_py_out, rif.ray_last_out};
         if (rif.ray_valid_out) begin
            if (prev_stall) begin
               checks++;
               if (cur !== prev_data) begin
                  errors++;
                  $display("FAIL hold_stable: got %0h expected %0h", cur, prev_data);
               end
            end
            if (rif.ray_ready_in) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ray: got (%0d,%0d) expected none",
                           rif.ray_px_out, rif.ray_py_out);
               end else begin
                  e = q.pop_front();
                  chk("ray_pixel", {rif.ray_px_out, rif.ray_py_out, rif.ray_last_out},
                      {e.px, e.py, e.last});
                  chk("ray_dx", rif.ray_dx_out, enc_x(e.px, e.py));
                  chk("ray_dy", rif.ray_dy_out, enc_y(e.px, e.py));
                  chk("ray_dz", rif.ray_dz_out, ~enc_x(e.px, e.py));
                  chk("frame_done", 32'(frame_done), 32'(e.last));
                  if (e.last) busy_chk = 1'b1;
               end
            end
         end
         prev_stall = rif.ray_valid_out && !rif.ray_ready_in;
         prev_data  = cur;
      end
   end

   // Independent count of SCAN cycles, taken from the x/y the DUT presents
   int   scan_cyc = 0;
   logic seen_last = 1'b0;
   logic scan_over = 1'b0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (busy && !prev_busy) begin
         scan_cyc  = 0;
         seen_last = 1'b0;
         scan_over = 1'b0;
      end
      if (busy && !scan_over) begin
         if (seen_last && !(x_out == 11'(W-1) && y_out == 10'(H-1)))
            scan_over = 1'b1;
         else begin
            scan_cyc++;
            if (x_out == 11'(W-1) && y_out == 10'(H-1)) seen_last = 1'b1;
         end
      end
      prev_busy = busy;
   end

   int lat;
   int n;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      rif.ray_ready_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_valid", 32'(rif.ray_valid_out), 32'd0);
      chk("rst_x", 32'(x_out), 32'd0);
      chk("rst_y", 32'(y_out), 32'd0);

      // Full frame with ready high, plus first-ray latency
      push_frame();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      lat = 0;
      while (!rif.ray_valid_out && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("first_latency", 32'(lat), 32'(L + 1));
      wait_frame(300);

      // Start while busy is ignored
      push_frame();
      pulse_start();
      repeat (20) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_frame(300);
      repeat (20) @(posedge clk);
      #1 chk("idle_no_ray", 32'(rif.ray_valid_out), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
`ifdef PIXEL_SEQ_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'd2);
`endif

      // Backpressure: only D issues fit before ready returns
      rif.ray_ready_in = 1'b0;
      push_frame();
      pulse_start();
      repeat (39) @(posedge clk);
      #1 chk("bp_valid", 32'(rif.ray_valid_out), 32'd1);
      chk("bp_next_pixel", 32'({y_out, x_out}), 32'({10'd1, 11'd0}));
      chk("bp_pending", 32'(q.size()), 32'(W * H));
      rif.ray_ready_in = 1'b1;
      wait_frame(300);
`ifdef PIXEL_SEQ_FRAME_CNT_EN
      chk("stall_cnt", stall_cnt, 32'(scan_cyc - W * H));
      chk("stall_nonzero", 32'(stall_cnt > 0), 32'd1);
`endif

      // Ready toggling every cycle
      push_frame();
      pulse_start();
      for (n = 0; n < 400; n++) begin
         @(posedge clk); #1 rif.ray_ready_in = ~rif.ray_ready_in;
         if (q.size() == 0 && !busy) break;
      end
      chk("toggle_drained", 32'(q.size()), 32'd0);
      rif.ray_ready_in = 1'b1;
      wait_frame(50);

      // Reset mid-frame once pixel (1,1) is next, i.e. five issued
      push_frame();
      pulse_start();
      for (n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         if (x_out == 11'd1 && y_out == 10'd1) break;
      end
      chk("reached_pixel5", 32'(n < 200), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(rif.ray_valid_out), 32'd0);
      chk("mid_rst_xy", 32'({y_out, x_out}), 32'd0);
      chk("mid_rst_done", 32'(frame_done), 32'd0);
      rst = 1'b0;
      q.delete();
      repeat (30) @(posedge clk);
      #1 chk("no_stale_ray", 32'(rif.ray_valid_out), 32'd0);
      push_frame();
      pulse_start();
      wait_frame(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
